// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
// Shared definitions for the GPR writeback path: register-file geometry,
// the writeback request record and the writeback source identifiers.
// Imported by gpr_wb_arbiter_if, gpr_scoreboard and gpr_wb_arbiter.
// -----------------------------------------------------------------------------
package gpr_pkg;

  localparam int XLEN       = 64;  // GPR / writeback data width
  localparam int NREG       = 32;  // architectural GPR count
  localparam int REG_ADDR_W = 5;   // clog2(NREG)
  localparam int PC_W       = 64;  // instruction address width

  // One writeback request as presented by a source.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [PC_W-1:0]       pc;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_if
// Bundles the writeback-arbiter signals: the ALU and LSU writeback requests
// with their ready returns, the issue-stage scoreboard set, the busy vector,
// and the register-file write port.
//   master : the surrounding pipeline (drives requests/issue, sees grants)
//   slave  : gpr_wb_arbiter
// Optional commit-trace signals (commit_valid/commit_pc/commit_rd) exist only
// when GPR_WB_COMMIT_TRACE_EN is defined.
// -----------------------------------------------------------------------------
interface gpr_wb_arbiter_if;
  import gpr_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic [PC_W-1:0]       alu_pc;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic [PC_W-1:0]       lsu_pc;

  logic                  issue_set;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [NREG-1:0]       busy;

  logic                  rf_wen;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;

`ifdef GPR_WB_COMMIT_TRACE_EN
  logic                  commit_valid;
  logic [PC_W-1:0]       commit_pc;
  logic [REG_ADDR_W-1:0] commit_rd;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, alu_pc,
    output lsu_valid, lsu_rd, lsu_data, lsu_pc,
    output issue_set, issue_rd,
    input  alu_ready, lsu_ready, busy,
    input  rf_wen, rf_waddr, rf_wdata
`ifdef GPR_WB_COMMIT_TRACE_EN
    , input commit_valid, commit_pc, commit_rd
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, alu_pc,
    input  lsu_valid, lsu_rd, lsu_data, lsu_pc,
    input  issue_set, issue_rd,
    output alu_ready, lsu_ready, busy,
    output rf_wen, rf_waddr, rf_wdata
`ifdef GPR_WB_COMMIT_TRACE_EN
    , output commit_valid, commit_pc, commit_rd
`endif
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
// Per-register pending-write vector. A set marks a register as having an
// in-flight producer; a clear retires it. When both target the same register
// in one cycle the set wins, since the newly issued producer supersedes the
// one completing. Register 0 is hardwired not-busy.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   set_en / set_rd     : mark set_rd busy on the next edge
//   clr_en / clr_rd     : mark clr_rd free on the next edge
//   busy                : current scoreboard
// -----------------------------------------------------------------------------
module gpr_scoreboard
  import gpr_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NREG-1:0]       busy
);

  logic [NREG-1:0] busy_nxt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    // Applied after the clear so that a same-register collision keeps the bit set.
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
// Arbitrates the ALU/CSR and LSU writeback sources onto the single GPR write
// port and keeps the RAW-hazard busy scoreboard.
//   - LSU has fixed priority; an ALU request denied STARVE_MAX consecutive
//     cycles gets priority on the next contended cycle.
//   - Readies are combinational from the valids and the starvation counter.
//   - The write port is registered: a handshake in cycle N writes in N+1.
//   - Writes to x0 are accepted but never enable the register file.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   wb           : gpr_wb_arbiter_if.slave (requests, readies, issue set,
//                  busy vector, register-file write port)
// Optional feature: define GPR_WB_COMMIT_TRACE_EN to add registered
// commit_valid/commit_pc/commit_rd for the difftest/trace step hook.
// -----------------------------------------------------------------------------
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       clock,
  input  logic       reset,
  gpr_wb_arbiter_if.slave wb
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  wb_req_t           alu_req;
  wb_req_t           lsu_req;
  wb_req_t           win_req;
  wb_src_e           grant_src;
  logic              alu_grant;
  logic              lsu_grant;
  logic              starved;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_nxt;

  logic                  rf_wen_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;

  assign alu_req = '{valid: wb.alu_valid, rd: wb.alu_rd, data: wb.alu_data, pc: wb.alu_pc};
  assign lsu_req = '{valid: wb.lsu_valid, rd: wb.lsu_rd, data: wb.lsu_data, pc: wb.lsu_pc};

  // Grant logic sees only valids and the counter; rd/data never reach ready.
  assign starved   = (starve_cnt == CNT_MAX);
  assign alu_grant = wb.alu_valid && (!wb.lsu_valid || starved);
  assign lsu_grant = wb.lsu_valid && !alu_grant;
  assign grant_src = alu_grant ? WB_SRC_ALU : WB_SRC_LSU;
  // With no grant the LSU request is selected, whose valid is then 0, so
  // win_req.valid is exactly "a handshake happens this cycle".
  assign win_req   = (grant_src == WB_SRC_ALU) ? alu_req : lsu_req;

  assign wb.alu_ready = alu_grant;
  assign wb.lsu_ready = lsu_grant;

  // A denied ALU request only occurs below saturation (at STARVE_MAX it wins).
  always_comb begin
    starve_nxt = starve_cnt;
    if (alu_grant)                 starve_nxt = '0;
    else if (wb.alu_valid && !starved) starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      rf_wen_q   <= win_req.valid && (win_req.rd != '0);
      if (win_req.valid) begin
        rf_waddr_q <= win_req.rd;
        rf_wdata_q <= win_req.data;
      end
    end
  end

  assign wb.rf_wen   = rf_wen_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;

  gpr_scoreboard u_scoreboard (
    .clock  (clock),
    .reset  (reset),
    .set_en (wb.issue_set),
    .set_rd (wb.issue_rd),
    .clr_en (win_req.valid),
    .clr_rd (win_req.rd),
    .busy   (wb.busy)
  );

`ifdef GPR_WB_COMMIT_TRACE_EN
  logic                  commit_valid_q;
  logic [PC_W-1:0]       commit_pc_q;
  logic [REG_ADDR_W-1:0] commit_rd_q;

  // Every handshake commits, including x0 destinations.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_rd_q    <= '0;
    end else begin
      commit_valid_q <= win_req.valid;
      if (win_req.valid) begin
        commit_pc_q <= win_req.pc;
        commit_rd_q <= win_req.rd;
      end
    end
  end

  assign wb.commit_valid = commit_valid_q;
  assign wb.commit_pc    = commit_pc_q;
  assign wb.commit_rd    = commit_rd_q;
`else
  // PCs only feed the commit trace; without it they terminate here.
  logic unused_pc;
  assign unused_pc = ^win_req.pc;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpr_wb_arbiter
// Directed bench for gpr_wb_arbiter with hand-computed expectations.
// Inputs change 1 ns after the rising edge; registered outputs are sampled
// 1 ns after the rising edge, combinational readies 1 ns after the drive.
// -----------------------------------------------------------------------------
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  gpr_wb_arbiter_if wb ();

  gpr_wb_arbiter #(.STARVE_MAX(3)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0; wb.alu_pc = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0; wb.lsu_pc = '0;
    wb.issue_set = 1'b0; wb.issue_rd = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] data);
    wb.alu_valid = 1'b1; wb.alu_rd = rd; wb.alu_data = data; wb.alu_pc = 64'h8000_0000 + 64'(rd);
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [63:0] data);
    wb.lsu_valid = 1'b1; wb.lsu_rd = rd; wb.lsu_data = data; wb.lsu_pc = 64'h9000_0000 + 64'(rd);
  endtask

  task automatic issue(input logic [4:0] rd);
    wb.issue_set = 1'b1; wb.issue_rd = rd;
  endtask

  task automatic test_reset();
    tests++;
    if (wb.rf_wen !== 1'b0 || wb.rf_waddr !== 5'd0 || wb.rf_wdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_wport: got wen=%b waddr=%0d wdata=%h, want 0/0/0", wb.rf_wen, wb.rf_waddr, wb.rf_wdata);
    end
    tests++;
    if (wb.busy !== 32'd0) begin
      fails++;
      $display("FAIL reset_busy: got %h, want 0", wb.busy);
    end
    tests++;
    if (wb.alu_ready !== 1'b0 || wb.lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got alu=%b lsu=%b, want 0/0", wb.alu_ready, wb.lsu_ready);
    end
  endtask

  task automatic test_alu_only();
    issue(5'd5);
    step();
    wb.issue_set = 1'b0;
    tests++;
    if (wb.busy !== 32'h0000_0020) begin
      fails++;
      $display("FAIL alu_busy_set: got %h, want 00000020", wb.busy);
    end
    drive_alu(5'd5, 64'h1234);
    #1;
    tests++;
    if (wb.alu_ready !== 1'b1 || wb.lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL alu_ready: got alu=%b lsu=%b, want 1/0", wb.alu_ready, wb.lsu_ready);
    end
    step();
    idle();
    tests++;
    if (wb.rf_wen !== 1'b1 || wb.rf_waddr !== 5'd5 || wb.rf_wdata !== 64'h1234) begin
      fails++;
      $display("FAIL alu_write: got wen=%b waddr=%0d wdata=%h, want 1/5/1234", wb.rf_wen, wb.rf_waddr, wb.rf_wdata);
    end
    tests++;
    if (wb.busy !== 32'd0) begin
      fails++;
      $display("FAIL alu_busy_clr: got %h, want 0", wb.busy);
    end
`ifdef GPR_WB_COMMIT_TRACE_EN
    tests++;
    if (wb.commit_valid !== 1'b1 || wb.commit_pc !== 64'h8000_0005 || wb.commit_rd !== 5'd5) begin
      fails++;
      $display("FAIL alu_commit: got v=%b pc=%h rd=%0d, want 1/80000005/5", wb.commit_valid, wb.commit_pc, wb.commit_rd);
    end
`endif
    step();
    tests++;
    if (wb.rf_wen !== 1'b0 || wb.rf_waddr !== 5'd5 || wb.rf_wdata !== 64'h1234) begin
      fails++;
      $display("FAIL alu_hold: got wen=%b waddr=%0d wdata=%h, want 0/5/1234", wb.rf_wen, wb.rf_waddr, wb.rf_wdata);
    end
  endtask

  task automatic test_lsu_only();
    drive_lsu(5'd9, 64'hdead_beef_0000_0001);
    #1;
    tests++;
    if (wb.lsu_ready !== 1'b1 || wb.alu_ready !== 1'b0) begin
      fails++;
      $display("FAIL lsu_ready: got alu=%b lsu=%b, want 0/1", wb.alu_ready, wb.lsu_ready);
    end
    step();
    idle();
    tests++;
    if (wb.rf_wen !== 1'b1 || wb.rf_waddr !== 5'd9 || wb.rf_wdata !== 64'hdead_beef_0000_0001 || wb.busy !== 32'd0) begin
      fails++;
      $display("FAIL lsu_write_notbusy: got wen=%b waddr=%0d wdata=%h busy=%h, want 1/9/deadbeef00000001/0",
               wb.rf_wen, wb.rf_waddr, wb.rf_wdata, wb.busy);
    end
  endtask

  task automatic test_x0_write();
    drive_lsu(5'd0, 64'h55);
    #1;
    tests++;
    if (wb.lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_ready: got %b, want 1", wb.lsu_ready);
    end
    step();
    idle();
    tests++;
    if (wb.rf_wen !== 1'b0 || wb.busy !== 32'd0) begin
      fails++;
      $display("FAIL x0_write: got wen=%b busy=%h, want 0/0", wb.rf_wen, wb.busy);
    end
`ifdef GPR_WB_COMMIT_TRACE_EN
    tests++;
    if (wb.commit_valid !== 1'b1 || wb.commit_rd !== 5'd0 || wb.commit_pc !== 64'h9000_0000) begin
      fails++;
      $display("FAIL x0_commit: got v=%b rd=%0d pc=%h, want 1/0/90000000", wb.commit_valid, wb.commit_rd, wb.commit_pc);
    end
`endif
    issue(5'd0);
    step();
    wb.issue_set = 1'b0;
    tests++;
    if (wb.busy !== 32'd0) begin
      fails++;
      $display("FAIL x0_issue: got busy=%h, want 0", wb.busy);
    end
  endtask

  // Both sources valid every cycle: LSU, LSU, LSU, ALU, LSU.
  task automatic check_contention(input string tag);
    for (int c = 0; c < 5; c++) begin
      logic exp_alu;
      exp_alu = (c == 3);
      #1;
      tests++;
      if (wb.alu_ready !== exp_alu || wb.lsu_ready !== !exp_alu) begin
        fails++;
        $display("FAIL %s_grant_c%0d: got alu=%b lsu=%b, want %b/%b", tag, c, wb.alu_ready, wb.lsu_ready, exp_alu, !exp_alu);
      end
      step();
      tests++;
      if (wb.rf_waddr !== (exp_alu ? 5'd1 : 5'd2) || wb.rf_wdata !== (exp_alu ? 64'haaaa : 64'hbbbb)) begin
        fails++;
        $display("FAIL %s_write_c%0d: got waddr=%0d wdata=%h, want %0d", tag, c, wb.rf_waddr, wb.rf_wdata, exp_alu ? 1 : 2);
      end
    end
  endtask

  task automatic test_contention();
    drive_alu(5'd1, 64'haaaa);
    drive_lsu(5'd2, 64'hbbbb);
    check_contention("contend");
    idle();
  endtask

  task automatic test_collision();
    issue(5'd7);
    step();
    // ALU retires r7 while a new producer of r7 issues: busy must stay set.
    drive_alu(5'd7, 64'h77);
    issue(5'd7);
    step();
    idle();
    tests++;
    if (wb.busy !== 32'h0000_0080 || wb.rf_wen !== 1'b1 || wb.rf_waddr !== 5'd7) begin
      fails++;
      $display("FAIL collide_same: got busy=%h wen=%b waddr=%0d, want 00000080/1/7", wb.busy, wb.rf_wen, wb.rf_waddr);
    end
    drive_lsu(5'd7, 64'h78);
    issue(5'd3);
    step();
    idle();
    tests++;
    if (wb.busy !== 32'h0000_0008) begin
      fails++;
      $display("FAIL collide_diff: got busy=%h, want 00000008", wb.busy);
    end
  endtask

  task automatic test_async_reset();
    issue(5'd4); drive_lsu(5'd3, 64'h33);
    step(); idle();
    issue(5'd5);
    step();
    issue(5'd6); drive_alu(5'd1, 64'haaaa); drive_lsu(5'd10, 64'hcc);
    step();
    issue(5'd7);
    step();
    wb.issue_set = 1'b0;
    tests++;
    if (wb.busy !== 32'h0000_00f0 || wb.rf_wen !== 1'b1 || wb.rf_waddr !== 5'd10) begin
      fails++;
      $display("FAIL areset_setup: got busy=%h wen=%b waddr=%0d, want 000000f0/1/10", wb.busy, wb.rf_wen, wb.rf_waddr);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (wb.busy !== 32'd0 || wb.rf_wen !== 1'b0 || wb.rf_waddr !== 5'd0 || wb.rf_wdata !== 64'd0) begin
      fails++;
      $display("FAIL areset_immediate: got busy=%h wen=%b waddr=%0d wdata=%h, want 0/0/0/0",
               wb.busy, wb.rf_wen, wb.rf_waddr, wb.rf_wdata);
    end
    step();
    reset = 1'b0;
    // Counter restarted at 0: the same L,L,L,A,L pattern must reappear.
    drive_alu(5'd1, 64'haaaa);
    drive_lsu(5'd2, 64'hbbbb);
    check_contention("areset");
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle();
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_alu_only();
    test_lsu_only();
    test_x0_write();
    test_contention();
    test_collision();
    test_async_reset();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
